booth_job_ctrl: RTL

- Job sequencer wrapped around the Booth multiplier (datapath plus its control unit).
- Accepts signed operand pairs over a valid/ready handshake and holds them stable for the datapath.
- Drives the datapath's start/reset pulse and waits for its fin level.
- Captures the product and presents it downstream over a valid/ready handshake, with a watchdog that flags a job whose fin never arrives.

---
 rtl/booth_pkg.sv | 29 ++
 rtl/booth_wdog.sv | 50 +++++
 rtl/booth_job_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier job sequencer:
// FSM state encoding, default parameter values and the watchdog
// counter width helper.
package booth_pkg;

  // Sequencer states, fixed 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Default operand width (signed two's complement).
  localparam int DEF_N       = 2;
  // Default WAIT cycles during which dp_fin is ignored.
  localparam int DEF_MIN_LAT = 2;
  // Default WAIT cycles before a job is aborted.
  localparam int DEF_TIMEOUT = 16;

  // Width of a counter that must hold 0 .. timeout-1.
  function automatic int cnt_width(input int timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

  // Counter width for the default timeout.
  localparam int CNT_W = cnt_width(DEF_TIMEOUT);

endpackage

// File: rtl/booth_wdog.sv
// WAIT-state cycle counter. Cleared when a job is launched, counts every
// WAIT cycle, and reports when the stale-fin mask window has passed
// (min_ok) and when the job has run out of time (expired).
module booth_wdog
  import booth_pkg::*;
#(
  parameter int MIN_LAT = DEF_MIN_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = cnt_width(TIMEOUT)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic          min_ok,
  output logic          expired,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority over increment, otherwise hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // fin is only trusted once the previous job's level has had time to drop.
  assign min_ok  = (cnt_q >= CW'(MIN_LAT));
  // Last WAIT cycle before the job is declared dead.
  assign expired = (cnt_q == CW'(TIMEOUT - 1));
  assign cnt     = cnt_q;

endmodule

// File: rtl/booth_job_ctrl.sv
// Job sequencer around the Booth multiplier datapath and its control unit.
// Accepts an operand pair, pulses the datapath start, waits for fin
// (ignoring a stale fin for the first MIN_LAT cycles), captures the product
// and hands it downstream. A watchdog aborts a job whose fin never arrives
// and reports it with out_err=1 and out_p=0.
// TIMEOUT must exceed MIN_LAT+6 so a healthy job always finishes first.
module booth_job_ctrl
  import booth_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int MIN_LAT = DEF_MIN_LAT,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*N-1:0]   out_p,
  output logic             out_err,
  output logic             dp_start,
  output logic [N-1:0]     dp_m,
  output logic [N-1:0]     dp_q,
  input  logic             dp_fin,
  input  logic [2*N-1:0]   dp_product
);

  localparam int CW = cnt_width(TIMEOUT);

  state_e           state_q,     state_d;
  logic [N-1:0]     dp_m_q,      dp_m_d;
  logic [N-1:0]     dp_q_q,      dp_q_d;
  logic [2*N-1:0]   out_p_q,     out_p_d;
  logic             out_valid_q, out_valid_d;
  logic             out_err_q,   out_err_d;

  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic             min_ok_s;
  logic             expired_s;
  logic [CW-1:0]    cnt_s;

  booth_wdog #(
    .MIN_LAT (MIN_LAT),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr_s),
    .en      (cnt_en_s),
    .min_ok  (min_ok_s),
    .expired (expired_s),
    .cnt     (cnt_s)
  );

  // Next-state, operand latch, result capture and watchdog control.
  always_comb begin
    state_d     = state_q;
    dp_m_d      = dp_m_q;
    dp_q_d      = dp_q_q;
    out_p_d     = out_p_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    cnt_clr_s   = 1'b0;
    cnt_en_s    = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dp_m_d  = in_a;
          dp_q_d  = in_b;
          state_d = LAUNCH;
        end else begin
          state_d = IDLE;
        end
      end

      LAUNCH: begin
        cnt_clr_s = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        cnt_en_s = 1'b1;
        // A genuine fin beats a coincident timeout.
        if (min_ok_s && dp_fin) begin
          out_p_d     = dp_product;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else if (expired_s) begin
          out_p_d     = {(2*N){1'b0}};
          out_err_d   = 1'b1;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = WAIT;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dp_m_q      <= {N{1'b0}};
      dp_q_q      <= {N{1'b0}};
      out_p_q     <= {(2*N){1'b0}};
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dp_m_q      <= dp_m_d;
      dp_q_q      <= dp_q_d;
      out_p_q     <= out_p_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
    end
  end

  // The datapath is held in reset whenever this block is, so it never runs
  // on operands that were discarded.
  assign dp_start  = reset | (state_q == LAUNCH);
  assign in_ready  = (state_q == IDLE);
  assign dp_m      = dp_m_q;
  assign dp_q      = dp_q_q;
  assign out_p     = out_p_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;

endmodule
